// File: rtl/serial_paralelo_rx_align.sv
// Receive deserializer: hunts for COM at any bit offset, locks byte alignment,
// then classifies each aligned byte as IDLE, COM or data.
module serial_paralelo_rx_align #(
  parameter int unsigned BC_COUNT = 4,
  parameter logic [7:0]  COM      = 8'hBC,
  parameter logic [7:0]  IDLE     = 8'h7C
) (
  input  logic       clk_32f,
  input  logic       rst,
  input  logic       data_in,
  output logic       active,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       idle_out
);

  typedef enum logic [1:0] {S_SEARCH, S_ALIGNED, S_ACTIVE} state_e;

  localparam logic [3:0] BC_LIM = 4'(BC_COUNT);

  state_e     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] com_cnt_q, com_cnt_d;
  logic       active_q, active_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       idle_q, idle_d;

  logic       boundary;
  logic       is_com;
  logic       is_idle;
  logic [3:0] com_inc;

  assign boundary = (bit_cnt_q == 3'd0);
  assign is_com   = (sr_q == COM);
  assign is_idle  = (sr_q == IDLE);
  // Saturating increment keeps BC_COUNT=1 reachable from the re-align path.
  assign com_inc  = (com_cnt_q >= BC_LIM) ? BC_LIM : com_cnt_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    sr_d      = {sr_q[6:0], data_in};
    bit_cnt_d = bit_cnt_q;
    com_cnt_d = com_cnt_q;
    active_d  = active_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    idle_d    = idle_q;
    unique case (state_q)
      S_SEARCH: begin
        if (is_com) begin
          bit_cnt_d = 3'd1;
          com_cnt_d = 4'd1;
          if (BC_COUNT > 1) begin
            state_d = S_ALIGNED;
          end else begin
            state_d  = S_ACTIVE;
            active_d = 1'b1;
          end
        end else begin
          bit_cnt_d = 3'd0;
        end
      end
      S_ALIGNED: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (is_com) begin
            com_cnt_d = com_inc;
            if (com_inc == BC_LIM) begin
              state_d  = S_ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            // False or lost alignment: resume bit-by-bit hunting.
            state_d   = S_SEARCH;
            com_cnt_d = 4'd0;
            bit_cnt_d = 3'd0;
          end
        end
      end
      S_ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (is_idle) begin
            idle_d = 1'b1;
          end else if (is_com) begin
            // Upstream went inactive; keep the byte phase, recount COMs.
            state_d   = S_ALIGNED;
            active_d  = 1'b0;
            idle_d    = 1'b0;
            com_cnt_d = 4'd1;
          end else begin
            data_d  = sr_q;
            valid_d = 1'b1;
            idle_d  = 1'b0;
          end
        end
      end
      default: state_d = S_SEARCH;
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (rst) begin
      state_q   <= S_SEARCH;
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      com_cnt_q <= 4'd0;
      active_q  <= 1'b0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      idle_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      active_q  <= active_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      idle_q    <= idle_d;
    end
  end

  assign active    = active_q;
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign idle_out  = idle_q;

endmodule

// File: tb/tb_serial_paralelo_rx_align.sv
// Byte-table bench for serial_paralelo_rx_align: each record is a byte (or bit
// fragment) plus the outputs expected one edge after its last bit.
module tb_serial_paralelo_rx_align;

  logic       clk_32f = 1'b0;
  logic       rst;
  logic       data_in;
  logic       active;
  logic [7:0] data_out;
  logic       valid_out;
  logic       idle_out;

  int n_vec = 0;
  int n_err = 0;

  serial_paralelo_rx_align #(.BC_COUNT(4), .COM(8'hBC), .IDLE(8'h7C)) dut (
    .clk_32f  (clk_32f),
    .rst      (rst),
    .data_in  (data_in),
    .active   (active),
    .data_out (data_out),
    .valid_out(valid_out),
    .idle_out (idle_out)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct {
    logic [7:0] b;
    int         n;
    bit         chk;
    logic       act;
    logic       vld;
    logic       idle;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [7:0] b, input int n, input bit c,
                              input logic a, input logic v, input logic i,
                              input logic [7:0] d);
    vec_t t;
    t.b = b; t.n = n; t.chk = c; t.act = a; t.vld = v; t.idle = i; t.dout = d;
    tbl.push_back(t);
  endfunction

  task automatic cmp(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic check_rec(input int k);
    cmp($sformatf("rec%0d active", k), {7'b0, active},    {7'b0, tbl[k].act});
    cmp($sformatf("rec%0d valid", k),  {7'b0, valid_out}, {7'b0, tbl[k].vld});
    cmp($sformatf("rec%0d idle", k),   {7'b0, idle_out},  {7'b0, tbl[k].idle});
    cmp($sformatf("rec%0d data", k),   data_out,          tbl[k].dout);
  endtask

  task automatic check_zero(input string nm);
    cmp({nm, " active"}, {7'b0, active},    8'h00);
    cmp({nm, " valid"},  {7'b0, valid_out}, 8'h00);
    cmp({nm, " idle"},   {7'b0, idle_out},  8'h00);
    cmp({nm, " data"},   data_out,          8'h00);
  endtask

  initial begin
    logic [7:0] cur;
    logic [7:0] bc;
    logic [7:0] mid;

    // ---- table: byte, nbits, check, active, valid, idle, data_out ----
    add(8'h05, 3, 0, 0, 0, 0, 8'h00);            // 3-bit misalignment 101
    add(8'hBC, 8, 1, 0, 0, 0, 8'h00);
    add(8'hBC, 8, 1, 0, 0, 0, 8'h00);
    add(8'hBC, 8, 1, 0, 0, 0, 8'h00);
    add(8'hBC, 8, 1, 1, 0, 0, 8'h00);            // 4th COM -> active
    add(8'h7C, 8, 1, 1, 0, 1, 8'h00);
    add(8'hA5, 8, 1, 1, 1, 0, 8'hA5);
    add(8'h3C, 8, 1, 1, 1, 0, 8'h3C);
    add(8'h7C, 8, 1, 1, 0, 1, 8'h3C);
    add(8'hBC, 8, 1, 0, 0, 0, 8'h3C);            // de-activate
    add(8'hBC, 8, 1, 0, 0, 0, 8'h3C);
    add(8'hBC, 8, 1, 0, 0, 0, 8'h3C);
    add(8'hBC, 8, 1, 1, 0, 0, 8'h3C);            // only 3 more COMs
    add(8'h5A, 8, 1, 1, 1, 0, 8'h5A);
    add(8'hBC, 8, 1, 0, 0, 0, 8'h5A);
    add(8'hBC, 8, 1, 0, 0, 0, 8'h5A);
    add(8'hBC, 8, 1, 0, 0, 0, 8'h5A);
    add(8'h7C, 8, 1, 0, 0, 0, 8'h5A);            // back to search
    add(8'hBC, 8, 1, 0, 0, 0, 8'h5A);
    add(8'hBC, 8, 1, 0, 0, 0, 8'h5A);
    add(8'hBC, 8, 1, 0, 0, 0, 8'h5A);
    add(8'h7C, 8, 1, 0, 0, 0, 8'h5A);            // failed lock
    add(8'h0B, 8, 1, 0, 0, 0, 8'h5A);            // 0B,C0 hide a false COM
    add(8'hC0, 8, 1, 0, 0, 0, 8'h5A);
    add(8'h00, 8, 1, 0, 0, 0, 8'h5A);
    add(8'hBC, 8, 1, 0, 0, 0, 8'h5A);
    add(8'hBC, 8, 1, 0, 0, 0, 8'h5A);
    add(8'hBC, 8, 1, 0, 0, 0, 8'h5A);
    add(8'hBC, 8, 1, 1, 0, 0, 8'h5A);
    add(8'h7C, 8, 1, 1, 0, 1, 8'h5A);

    // ---- reset held 3 cycles with random serial data ----
    rst = 1'b1;
    data_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      data_in = 1'($urandom_range(0, 1));
      @(posedge clk_32f);
      #1;
      check_zero($sformatf("reset%0d", k));
    end
    rst = 1'b0;
    drive_bit(1'b0);
    check_zero("post-reset");

    // ---- table walk: record k-1 is checked after the first bit of record k ----
    for (int i = 0; i < tbl.size(); i++) begin
      cur = tbl[i].b;
      for (int j = tbl[i].n - 1; j >= 0; j--) begin
        drive_bit(cur[j]);
        if (j == tbl[i].n - 1 && i > 0 && tbl[i-1].chk)
          check_rec(i - 1);
        else
          cmp($sformatf("rec%0d bit%0d no-strobe", i, j), {7'b0, valid_out}, 8'h00);
      end
    end

    // ---- reset in the middle of a data byte while active ----
    mid = 8'h96;
    drive_bit(mid[7]);
    check_rec(tbl.size() - 1);
    for (int j = 6; j >= 4; j--) drive_bit(mid[j]);
    rst = 1'b1;
    drive_bit(mid[3]);
    check_zero("mid-reset");
    rst = 1'b0;

    // ---- full 4xCOM needed to re-lock ----
    bc = 8'hBC;
    for (int k = 0; k < 4; k++) begin
      for (int j = 7; j >= 0; j--) begin
        drive_bit(bc[j]);
        if (j == 7 && k > 0)
          cmp($sformatf("relock com%0d active", k), {7'b0, active}, 8'h00);
      end
    end
    drive_bit(1'b0);
    cmp("relock active", {7'b0, active}, 8'h01);
    cmp("relock valid", {7'b0, valid_out}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
